// File: rtl/vga_sync_gen.sv
// VGA sync generator: lock delay after reset, pixel-strobe divider, x/y
// raster counters, and registered sync/active/blanking flags that always
// describe the x/y values presented in the same cycle.
module vga_sync_gen #(
  parameter int CLK_DIV     = 1,
  parameter int LOCK_CYCLES = 16,
  parameter int H_ACTIVE    = 640,
  parameter int H_FP        = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BP        = 48,
  parameter int V_ACTIVE    = 480,
  parameter int V_FP        = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BP        = 33,
  parameter bit SYNC_POL    = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic       locked,
  output logic       pix_en,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       h_sync,
  output logic       v_sync,
  output logic       active,
  output logic       blanking_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int LOCK_W  = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [LOCK_W-1:0] LOCK_LAST = LOCK_W'(LOCK_CYCLES - 1);
  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [9:0] X_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] Y_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] X_VIS    = 10'(H_ACTIVE);
  localparam logic [9:0] Y_VIS    = 10'(V_ACTIVE);
  localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

  logic [LOCK_W-1:0] lock_cnt, lock_cnt_nxt;
  logic [DIV_W-1:0]  div_cnt, div_cnt_nxt;
  logic              lock_done, locked_nxt, pix_en_nxt;
  logic [9:0]        x_nxt, y_nxt;
  logic              h_sync_nxt, v_sync_nxt, active_nxt, blank_nxt;

  // Next-state logic: every output is computed from the next x/y so the
  // registered flags line up with the registered counters with no lag.
  always_comb begin
    lock_done    = 1'b0;
    locked_nxt   = locked;
    lock_cnt_nxt = lock_cnt;
    div_cnt_nxt  = div_cnt;
    x_nxt        = x;
    y_nxt        = y;

    if (!locked) begin
      lock_cnt_nxt = lock_cnt + 1'b1;
      if (lock_cnt == LOCK_LAST) begin
        lock_done  = 1'b1;
        locked_nxt = 1'b1;
      end
    end

    // The divider phase restarts at lock so the first strobe lands
    // CLK_DIV-1 cycles after locked rises.
    if (lock_done) begin
      div_cnt_nxt = '0;
    end else if (locked) begin
      div_cnt_nxt = (div_cnt == DIV_LAST) ? '0 : div_cnt + 1'b1;
    end
    pix_en_nxt = locked_nxt && (div_cnt_nxt == DIV_LAST);

    if (pix_en) begin
      if (x == X_LAST) begin
        x_nxt = '0;
        y_nxt = (y == Y_LAST) ? '0 : y + 1'b1;
      end else begin
        x_nxt = x + 1'b1;
      end
    end

    h_sync_nxt = (x_nxt >= HS_START && x_nxt < HS_END) ? SYNC_POL : ~SYNC_POL;
    v_sync_nxt = (y_nxt >= VS_START && y_nxt < VS_END) ? SYNC_POL : ~SYNC_POL;
    active_nxt = locked_nxt && (x_nxt < X_VIS) && (y_nxt < Y_VIS);
    // Only the strobe that moves the counters into (0, V_ACTIVE) fires,
    // so the pulse stays one clk wide whatever CLK_DIV is.
    blank_nxt  = pix_en && (x_nxt == '0) && (y_nxt == Y_VIS);
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_cnt       <= '0;
      locked         <= 1'b0;
      div_cnt        <= '0;
      pix_en         <= 1'b0;
      x              <= '0;
      y              <= '0;
      h_sync         <= ~SYNC_POL;
      v_sync         <= ~SYNC_POL;
      active         <= 1'b0;
      blanking_start <= 1'b0;
    end else begin
      lock_cnt       <= lock_cnt_nxt;
      locked         <= locked_nxt;
      div_cnt        <= div_cnt_nxt;
      pix_en         <= pix_en_nxt;
      x              <= x_nxt;
      y              <= y_nxt;
      h_sync         <= h_sync_nxt;
      v_sync         <= v_sync_nxt;
      active         <= active_nxt;
      blanking_start <= blank_nxt;
    end
  end

endmodule

// File: tb/tb_vga_sync_gen.sv
// Testbench for vga_sync_gen: default 640x480 instance plus two small-raster
// instances (CLK_DIV=1 and CLK_DIV=4 with positive sync) so that whole frames
// fit in a short run. An arithmetic raster model is compared every cycle.
module tb_vga_sync_gen;

  logic clk = 1'b0;
  logic rst_n;
  int   n;
  int   total_count = 0;
  int   bad_count   = 0;

  logic       locked_a, pix_en_a, hs_a, vs_a, act_a, bs_a;
  logic [9:0] x_a, y_a;
  logic       locked_b, pix_en_b, hs_b, vs_b, act_b, bs_b;
  logic [9:0] x_b, y_b;
  logic       locked_c, pix_en_c, hs_c, vs_c, act_c, bs_c;
  logic [9:0] x_c, y_c;

  vga_sync_gen dut_a (
    .clk(clk), .rst_n(rst_n), .locked(locked_a), .pix_en(pix_en_a),
    .x(x_a), .y(y_a), .h_sync(hs_a), .v_sync(vs_a), .active(act_a),
    .blanking_start(bs_a)
  );

  vga_sync_gen #(
    .H_ACTIVE(10), .H_FP(2), .H_SYNC(3), .H_BP(5),
    .V_ACTIVE(6), .V_FP(2), .V_SYNC(2), .V_BP(2)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .locked(locked_b), .pix_en(pix_en_b),
    .x(x_b), .y(y_b), .h_sync(hs_b), .v_sync(vs_b), .active(act_b),
    .blanking_start(bs_b)
  );

  vga_sync_gen #(
    .CLK_DIV(4), .SYNC_POL(1'b1),
    .H_ACTIVE(10), .H_FP(2), .H_SYNC(3), .H_BP(5),
    .V_ACTIVE(6), .V_FP(2), .V_SYNC(2), .V_BP(2)
  ) dut_c (
    .clk(clk), .rst_n(rst_n), .locked(locked_c), .pix_en(pix_en_c),
    .x(x_c), .y(y_c), .h_sync(hs_c), .v_sync(vs_c), .active(act_c),
    .blanking_start(bs_c)
  );

  // 10 ns clock
  always #5 clk = ~clk;

  // Clock edges seen since reset release; the model derives everything from it.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) n <= 0;
    else        n <= n + 1;
  end

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] want);
    total_count++;
    if (got !== want) begin
      bad_count++;
      $display("[TB] FAIL %s: got %0h, want %0h (n=%0d)", name, got, want, n);
    end
  endtask

  task automatic applyStimulus(input logic level, input int delay_ns);
    #(delay_ns) rst_n = level;
  endtask

  // Expected {locked,pix_en,x,y,h_sync,v_sync,active,blanking_start} after
  // n edges: k cycles since lock, floor(k/div) strobes elapsed.
  function automatic logic [25:0] modelOut(input int cyc, input int lockc, input int div,
                                           input int ha, input int hfp, input int hsw, input int hbp,
                                           input int va, input int vfp, input int vsw, input int vbp,
                                           input bit pol);
    int ht, vt, k, p, xv, yv;
    logic pe, hsv, vsv, av, bv;
    ht = ha + hfp + hsw + hbp;
    vt = va + vfp + vsw + vbp;
    if (cyc < lockc) return {1'b0, 1'b0, 10'd0, 10'd0, ~pol, ~pol, 1'b0, 1'b0};
    k   = cyc - lockc;
    p   = k / div;
    xv  = p % ht;
    yv  = (p / ht) % vt;
    pe  = (k % div) == div - 1;
    hsv = (xv >= ha + hfp && xv < ha + hfp + hsw) ? pol : ~pol;
    vsv = (yv >= va + vfp && yv < va + vfp + vsw) ? pol : ~pol;
    av  = (xv < ha) && (yv < va);
    bv  = (xv == 0) && (yv == va) && (k % div == 0) && (k > 0);
    return {1'b1, pe, 10'(xv), 10'(yv), hsv, vsv, av, bv};
  endfunction

  // Every-cycle comparison of all three instances against the model.
  always @(negedge clk) begin
    checkOutput("model_a", 32'({locked_a, pix_en_a, x_a, y_a, hs_a, vs_a, act_a, bs_a}),
                32'(modelOut(n, 16, 1, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0)));
    checkOutput("model_b", 32'({locked_b, pix_en_b, x_b, y_b, hs_b, vs_b, act_b, bs_b}),
                32'(modelOut(n, 16, 1, 10, 2, 3, 5, 6, 2, 2, 2, 1'b0)));
    checkOutput("model_c", 32'({locked_c, pix_en_c, x_c, y_c, hs_c, vs_c, act_c, bs_c}),
                32'(modelOut(n, 16, 4, 10, 2, 3, 5, 6, 2, 2, 2, 1'b1)));
  end

  initial begin
    int k;
    int hs_low_a, vs_low_b, bs_cnt_b, act_cnt_b, pe_cnt_c, bs_cnt_c, vs_high_c, lock_early;
    hs_low_a = 0; vs_low_b = 0; bs_cnt_b = 0; act_cnt_b = 0;
    pe_cnt_c = 0; bs_cnt_c = 0; vs_high_c = 0; lock_early = 0;

    applyStimulus(1'b0, 0);
    repeat (3) @(negedge clk);
    checkOutput("rst_locked", 32'(locked_a), 32'd0);
    checkOutput("rst_xy", 32'({x_a, y_a}), 32'd0);
    checkOutput("rst_sync", 32'({hs_a, vs_a, hs_c, vs_c}), 32'b1100);
    applyStimulus(1'b1, 2);

    // Three lines of the default raster; ends at dut_a (300,2).
    for (int c = 0; c < 1916; c++) begin
      @(negedge clk);
      k = n - 16;
      if (n == 15) checkOutput("lock_early", 32'(locked_a), 32'd0);
      if (k == 0) begin
        checkOutput("lock_rise", 32'({locked_a, pix_en_a, act_a}), 32'b111);
        checkOutput("lock_xy", 32'({x_a, y_a}), 32'd0);
        checkOutput("div4_first", 32'({locked_c, pix_en_c}), 32'b10);
      end
      if (k == 1)   checkOutput("x_step", 32'(x_a), 32'd1);
      if (k == 3)   checkOutput("div4_pe", 32'(pix_en_c), 32'd1);
      if (k == 639) checkOutput("act_639", 32'({x_a, act_a}), {21'd0, 10'd639, 1'b1});
      if (k == 640) checkOutput("act_640", 32'({x_a, act_a}), {21'd0, 10'd640, 1'b0});
      if (k == 655) checkOutput("hs_655", 32'(hs_a), 32'd1);
      if (k == 656) checkOutput("hs_656", 32'(hs_a), 32'd0);
      if (k == 751) checkOutput("hs_751", 32'(hs_a), 32'd0);
      if (k == 752) checkOutput("hs_752", 32'(hs_a), 32'd1);
      if (k == 799) checkOutput("xy_799", 32'({x_a, y_a}), {12'd0, 10'd799, 10'd0});
      if (k == 800) checkOutput("xy_wrap", 32'({x_a, y_a}), {12'd0, 10'd0, 10'd1});
      if (k >= 0 && k < 800) hs_low_a += (hs_a == 1'b0) ? 1 : 0;

      if (k >= 0 && k < 240) begin
        vs_low_b  += (vs_b == 1'b0) ? 1 : 0;
        bs_cnt_b  += bs_b ? 1 : 0;
        act_cnt_b += act_b ? 1 : 0;
      end
      if (k == 120) checkOutput("blank_b", 32'({bs_b, act_b, x_b, y_b}), {10'd0, 1'b1, 1'b0, 10'd0, 10'd6});
      if (k == 239) checkOutput("end_b", 32'({x_b, y_b}), {12'd0, 10'd19, 10'd11});
      if (k == 240) checkOutput("wrap_b", 32'({x_b, y_b}), 32'd0);

      if (k >= 0 && k < 960) begin
        pe_cnt_c  += pix_en_c ? 1 : 0;
        bs_cnt_c  += bs_c ? 1 : 0;
        vs_high_c += vs_c ? 1 : 0;
      end
      if (k == 480) checkOutput("blank_c", 32'(bs_c), 32'd1);
      if (k == 481) checkOutput("blank_c_w", 32'({bs_c, x_c, y_c}), {11'd0, 1'b0, 10'd0, 10'd6});
      if (k == 959) checkOutput("end_c", 32'({x_c, y_c}), {12'd0, 10'd19, 10'd11});
      if (k == 960) checkOutput("wrap_c", 32'({x_c, y_c}), 32'd0);
    end

    checkOutput("hs_low_cnt", 32'(hs_low_a), 32'd96);
    checkOutput("vs_low_b", 32'(vs_low_b), 32'd40);
    checkOutput("blank_cnt_b", 32'(bs_cnt_b), 32'd1);
    checkOutput("act_cnt_b", 32'(act_cnt_b), 32'd60);
    checkOutput("pe_cnt_c", 32'(pe_cnt_c), 32'd240);
    checkOutput("blank_cnt_c", 32'(bs_cnt_c), 32'd1);
    checkOutput("vs_high_c", 32'(vs_high_c), 32'd160);
    checkOutput("pre_rst_xy", 32'({x_a, y_a}), {12'd0, 10'd300, 10'd2});

    // Mid-frame reset must clear outputs without waiting for a clock edge.
    applyStimulus(1'b0, 1);
    #1;
    checkOutput("async_a", 32'({locked_a, pix_en_a, x_a, y_a, hs_a, vs_a, act_a, bs_a}),
                {6'd0, 1'b0, 1'b0, 10'd0, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0});
    checkOutput("async_c", 32'({locked_c, x_c, y_c, hs_c, vs_c}), 32'd0);
    repeat (2) @(negedge clk);
    applyStimulus(1'b1, 2);

    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (n < 16) lock_early += locked_a ? 1 : 0;
      if (n == 16) checkOutput("relock_xy", 32'({locked_a, x_a, y_a, act_a}), {10'd0, 1'b1, 10'd0, 10'd0, 1'b1});
      if (n == 17) checkOutput("relock_step", 32'(x_a), 32'd1);
    end
    checkOutput("relock_wait", 32'(lock_early), 32'd0);

    $display("test done: total=%0d bad=%0d", total_count, bad_count);
    $finish;
  end

endmodule
